// File: rtl/uart_cmd_assembler.sv
// Packs pairs of UART bytes (opcode, then data) into 16-bit commands for the dispatcher.
// A partial command is dropped, with a one-cycle frm_err pulse, after an inter-byte timeout.
module uart_cmd_assembler #(
  parameter int TIMEOUT_CYC = 52080,
  parameter int TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  cmd,
  output logic        clr_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd_word,
  output logic        cmd_rdy,
  output logic        frm_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_DATA = 2'b01
  } state_t;

  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TIMER_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TIMER_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [15:0]     cmd_word_q, cmd_word_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            clr_rdy_q, clr_rdy_d;
  logic            frm_err_q, frm_err_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            accept_s;

  // Next-state and output logic; the ~clr_rdy term stops the same byte being taken twice.
  always_comb begin
    accept_s   = rdy & ~clr_rdy_q & ~cmd_rdy_q;
    state_d    = state_q;
    opcode_d   = opcode_q;
    cmd_word_d = cmd_word_q;
    cmd_rdy_d  = cmd_rdy_q & ~clr_cmd_rdy;
    clr_rdy_d  = 1'b0;
    frm_err_d  = 1'b0;
    timer_d    = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = TIMER_ZERO;
        if (accept_s) begin
          opcode_d  = cmd;
          clr_rdy_d = 1'b1;
          state_d   = WAIT_DATA;
        end else begin
          state_d   = IDLE;
        end
      end
      WAIT_DATA: begin
        if (accept_s) begin
          // A byte landing on the expiry cycle still completes the command.
          cmd_word_d = {opcode_q, cmd};
          cmd_rdy_d  = 1'b1;
          clr_rdy_d  = 1'b1;
          timer_d    = TIMER_ZERO;
          state_d    = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          frm_err_d  = 1'b1;
          timer_d    = TIMER_ZERO;
          state_d    = IDLE;
        end else begin
          timer_d    = timer_q + TIMER_ONE;
          state_d    = WAIT_DATA;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = TIMER_ZERO;
        cmd_rdy_d = 1'b0;
        clr_rdy_d = 1'b0;
        frm_err_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opcode_q   <= 8'h00;
      cmd_word_q <= 16'h0000;
      cmd_rdy_q  <= 1'b0;
      clr_rdy_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      timer_q    <= TIMER_ZERO;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      cmd_word_q <= cmd_word_d;
      cmd_rdy_q  <= cmd_rdy_d;
      clr_rdy_q  <= clr_rdy_d;
      frm_err_q  <= frm_err_d;
      timer_q    <= timer_d;
    end
  end

  assign clr_rdy  = clr_rdy_q;
  assign cmd_word = cmd_word_q;
  assign cmd_rdy  = cmd_rdy_q;
  assign frm_err  = frm_err_q;

endmodule
